// File: rtl/captura_jogada.sv
// captura_jogada: debounced single-button capture with per-jogada timeout
// and release wait, driven by an enable level from the game FSM.
module captura_jogada #(
    parameter int DEBOUNCE = 4,
    parameter int TIMEOUT  = 3000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] botoes,
    input  logic       habilita,
    input  logic       zera,
    output logic [3:0] jogada,
    output logic       jogada_feita,
    output logic       timeout,
    output logic [2:0] db_estado
);
    localparam int DW = $clog2(DEBOUNCE);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        OCIOSO        = 3'd0,
        ESPERA_BOTAO  = 3'd1,
        FILTRA        = 3'd2,
        REGISTRA      = 3'd3,
        ESPERA_SOLTAR = 3'd4,
        ESGOTADO      = 3'd5
    } estado_t;

    estado_t       estado, proximo;
    logic [3:0]    cand, cand_n, jogada_n;
    logic [DW-1:0] db_cnt, db_n;
    logic [TW-1:0] to_cnt, to_n;
    logic          um_bit, db_fim, to_fim;

    assign um_bit = (botoes != 4'd0) && ((botoes & (botoes - 4'd1)) == 4'd0);
    assign db_fim = db_cnt == DW'(DEBOUNCE - 1);
    assign to_fim = to_cnt == TW'(TIMEOUT - 1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= OCIOSO;
            cand   <= '0;
            jogada <= '0;
            db_cnt <= '0;
            to_cnt <= '0;
        end else begin
            estado <= proximo;
            cand   <= cand_n;
            jogada <= jogada_n;
            db_cnt <= db_n;
            to_cnt <= to_n;
        end
    end

    // Timeout is tested before debounce completion so an expiring press never registers.
    always_comb begin
        proximo  = estado;
        cand_n   = cand;
        jogada_n = jogada;
        db_n     = db_cnt;
        to_n     = to_cnt;
        if (zera) begin
            proximo  = OCIOSO;
            jogada_n = '0;
            db_n     = '0;
            to_n     = '0;
        end else if (!habilita) begin
            proximo = OCIOSO;
        end else begin
            case (estado)
                OCIOSO: begin
                    proximo = ESPERA_BOTAO;
                    to_n    = '0;
                end
                ESPERA_BOTAO: begin
                    if (to_fim) proximo = ESGOTADO;
                    else begin
                        to_n = to_cnt + 1'b1;
                        if (um_bit) begin
                            cand_n  = botoes;
                            db_n    = '0;
                            proximo = FILTRA;
                        end
                    end
                end
                FILTRA: begin
                    if (to_fim) proximo = ESGOTADO;
                    else begin
                        to_n = to_cnt + 1'b1;
                        if (botoes != cand) proximo = ESPERA_BOTAO;
                        else if (db_fim) begin
                            proximo  = REGISTRA;
                            jogada_n = cand;
                        end else db_n = db_cnt + 1'b1;
                    end
                end
                REGISTRA: begin
                    proximo = ESPERA_SOLTAR;
                    db_n    = '0;
                end
                ESPERA_SOLTAR: begin
                    if (botoes != 4'd0) db_n = '0;
                    else if (db_fim) begin
                        proximo = ESPERA_BOTAO;
                        to_n    = '0;
                    end else db_n = db_cnt + 1'b1;
                end
                ESGOTADO: ;
                default: proximo = OCIOSO;
            endcase
        end
    end

    assign jogada_feita = estado == REGISTRA;
    assign timeout      = estado == ESGOTADO;
    assign db_estado    = estado;
endmodule

// File: tb/tb_captura_jogada.sv
// tb_captura_jogada: directed scenarios plus randomized stimulus, checked every
// cycle against a run-length model of press, release and timeout behaviour.
module tb_captura_jogada;
    localparam int DB = 4;
    localparam int TO = 20;
    localparam int M_IDLE = 0, M_WAIT = 1, M_PULSE = 2, M_HOLD = 3, M_EXP = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       habilita = 1'b0;
    logic       zera = 1'b0;
    logic [3:0] botoes = 4'd0;
    logic [3:0] jogada;
    logic       jogada_feita, timeout;
    logic [2:0] db_estado;

    int errors = 0, checks = 0, pulses = 0, p0 = 0;

    captura_jogada #(.DEBOUNCE(DB), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .botoes(botoes), .habilita(habilita), .zera(zera),
        .jogada(jogada), .jogada_feita(jogada_feita), .timeout(timeout), .db_estado(db_estado)
    );

    always #10 clock = ~clock;

    // Model: mode plus cycles waited, length of the current stable one-hot run and of the zero run.
    int         mode = M_IDLE, elapsed = 0, run = 0, zeros = 0;
    logic [3:0] val = 4'd0, mj = 4'd0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mode = M_IDLE; mj = 4'd0; run = 0; zeros = 0; elapsed = 0;
        end else if (zera) begin
            mode = M_IDLE; mj = 4'd0;
        end else if (!habilita) begin
            mode = M_IDLE;
        end else begin
            case (mode)
                M_IDLE: begin mode = M_WAIT; elapsed = 0; run = 0; end
                M_WAIT: begin
                    if (elapsed == TO - 1) mode = M_EXP;
                    else begin
                        elapsed++;
                        if (run == 0) begin
                            if ($countones(botoes) == 1) begin val = botoes; run = 1; end
                        end else if (botoes == val) begin
                            run++;
                            if (run == DB + 1) begin mode = M_PULSE; mj = val; end
                        end else run = 0;
                    end
                end
                M_PULSE: begin mode = M_HOLD; zeros = 0; end
                M_HOLD: begin
                    if (botoes != 4'd0) zeros = 0;
                    else begin
                        zeros++;
                        if (zeros == DB) begin mode = M_WAIT; elapsed = 0; run = 0; end
                    end
                end
                default: ;
            endcase
        end
    end

    function automatic logic [2:0] exp_db(input int m, input int r);
        case (m)
            M_IDLE:  return 3'd0;
            M_WAIT:  return (r == 0) ? 3'd1 : 3'd2;
            M_PULSE: return 3'd3;
            M_HOLD:  return 3'd4;
            default: return 3'd5;
        endcase
    endfunction

    always @(negedge clock) begin
        if (!reset) begin
            checks++;
            if ({jogada, jogada_feita, timeout, db_estado} !==
                {mj, mode == M_PULSE, mode == M_EXP, exp_db(mode, run)}) begin
                errors++;
                $display("FAIL cycle t=%0t: got jogada=%b feita=%b timeout=%b estado=%0d, expected jogada=%b feita=%b timeout=%b estado=%0d",
                         $time, jogada, jogada_feita, timeout, db_estado,
                         mj, mode == M_PULSE, mode == M_EXP, exp_db(mode, run));
            end
            if (jogada_feita) pulses++;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step(input logic [3:0] b, input int n);
        repeat (n) begin
            botoes = b;
            @(negedge clock);
            #1;
        end
    endtask

    initial begin
        #1 reset = 1'b1;
        @(negedge clock);
        #1;
        chk("reset_jogada", jogada, 0);
        chk("reset_feita", jogada_feita, 0);
        chk("reset_timeout", timeout, 0);
        chk("reset_estado", db_estado, 0);
        reset = 1'b0;
        step(4'd0, 1);
        chk("idle_estado", db_estado, 0);
        habilita = 1'b1;
        step(4'd0, 1);
        chk("enable_estado", db_estado, 1);
        // clean press
        p0 = pulses;
        step(4'b0010, 4);
        chk("clean_no_early_pulse", jogada_feita, 0);
        chk("clean_filtra", db_estado, 2);
        step(4'b0010, 1);
        chk("clean_pulse_at_5", jogada_feita, 1);
        chk("clean_jogada", jogada, 4'b0010);
        step(4'b0010, 5);
        chk("clean_one_pulse", pulses - p0, 1);
        chk("clean_no_timeout", timeout, 0);
        chk("clean_hold_estado", db_estado, 4);
        step(4'd0, 3);
        chk("release_3", db_estado, 4);
        step(4'd0, 1);
        chk("release_4", db_estado, 1);
        // bounce
        p0 = pulses;
        repeat (2) begin step(4'b0001, 2); step(4'd0, 2); end
        chk("bounce_no_pulse", pulses - p0, 0);
        step(4'b0001, 6);
        chk("bounce_one_pulse", pulses - p0, 1);
        chk("bounce_jogada", jogada, 4'b0001);
        step(4'd0, 4);
        chk("bounce_release", db_estado, 1);
        // multiple buttons until timeout
        p0 = pulses;
        step(4'b0101, 15);
        chk("multi_no_pulse", pulses - p0, 0);
        chk("multi_no_timeout_15", timeout, 0);
        step(4'b0101, 4);
        chk("multi_no_timeout_19", timeout, 0);
        step(4'b0101, 1);
        chk("multi_timeout_20", timeout, 1);
        chk("multi_estado", db_estado, 5);
        // timeout then recovery
        step(4'b1000, 8);
        chk("esgotado_ignores", timeout, 1);
        chk("esgotado_jogada", jogada, 4'b0001);
        chk("esgotado_no_pulse", pulses - p0, 0);
        zera = 1'b1;
        step(4'b1000, 1);
        zera = 1'b0;
        chk("zera_timeout", timeout, 0);
        chk("zera_jogada", jogada, 0);
        chk("zera_estado", db_estado, 0);
        step(4'd0, 1);
        step(4'b1000, 5);
        chk("recover_pulse", jogada_feita, 1);
        chk("recover_jogada", jogada, 4'b1000);
        step(4'd0, 5);
        chk("recover_release", db_estado, 1);
        // held button
        p0 = pulses;
        step(4'b0100, 50);
        chk("held_one_pulse", pulses - p0, 1);
        chk("held_no_timeout", timeout, 0);
        chk("held_estado", db_estado, 4);
        step(4'd0, 4);
        chk("held_release", db_estado, 1);
        habilita = 1'b0;
        step(4'd0, 2);
        chk("disable_estado", db_estado, 0);
        chk("disable_keeps_jogada", jogada, 4'b0100);
        habilita = 1'b1;
        step(4'd0, 1);
        // asynchronous reset mid-FILTRA
        step(4'b0010, 2);
        chk("pre_reset_filtra", db_estado, 2);
        #4 reset = 1'b1;
        #1;
        chk("async_jogada", jogada, 0);
        chk("async_feita", jogada_feita, 0);
        chk("async_timeout", timeout, 0);
        chk("async_estado", db_estado, 0);
        #2 reset = 1'b0;
        botoes = 4'd0;
        p0 = pulses;
        step(4'd0, 6);
        chk("post_reset_no_pulse", pulses - p0, 0);
        chk("post_reset_estado", db_estado, 1);
        // randomized
        for (int i = 0; i < 600; i++) begin
            int r, len;
            logic [3:0] b;
            r = $urandom_range(0, 9);
            len = $urandom_range(1, 10);
            b = (r < 5) ? (4'b0001 << $urandom_range(0, 3)) : (r < 8) ? 4'd0 : 4'($urandom);
            habilita = $urandom_range(0, 14) != 0;
            zera = $urandom_range(0, 29) == 0;
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1;
                #2 reset = 1'b0;
            end
            step(b, len);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/captura_jogada.md
CAPTURA_JOGADA -- requirements
Module: captura_jogada

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clock and reset.
REQ-002 Parameter DEBOUNCE, default 4, SHALL be the number of consecutive stable cycles needed to accept a press or a release (range 2..255).
REQ-003 Parameter TIMEOUT, default 3000, SHALL be the number of cycles allowed without an accepted press (range 2..2^16-1).
REQ-004 Port clock, input, 1, SHALL be the system clock; all state updates occur on its rising edge.
REQ-005 Port reset, input, 1, SHALL be the asynchronous active-high reset.
REQ-006 Port botoes, input, 4, SHALL be the raw player buttons, already synchronised to clock, with 1 = pressed.
REQ-007 Port habilita, input, 1, SHALL be a level from the game FSM that enables capture of one jogada.
REQ-008 Port zera, input, 1, SHALL be a synchronous clear of the block.
REQ-009 Port jogada, output, 4, SHALL be the registered one-hot code of the last accepted button.
REQ-010 Port jogada_feita, output, 1, SHALL be a one-cycle pulse marking a newly accepted jogada.
REQ-011 Port timeout, output, 1, SHALL be a level indicating that the time for a press has expired.
REQ-012 Port db_estado, output, 3, SHALL carry the current FSM state encoding for debug.

Function
REQ-013 The FSM SHALL have these states and encodings: OCIOSO=0, ESPERA_BOTAO=1, FILTRA=2, REGISTRA=3, ESPERA_SOLTAR=4, ESGOTADO=5.
REQ-014 State priority SHALL be: zera=1 forces OCIOSO, clears jogada and clears both counters; otherwise habilita=0 forces OCIOSO; otherwise the transitions below apply.
REQ-015 In OCIOSO, with habilita=1, the next state SHALL be ESPERA_BOTAO, with the timeout counter cleared.
REQ-016 In ESPERA_BOTAO:
- A botoes value with exactly one bit set SHALL latch that value as the candidate and go to FILTRA, with the debounce counter set to 0.
- Zero or multiple bits set SHALL keep the state.
REQ-017 In FILTRA:
- botoes equal to the candidate SHALL increment the debounce counter.
- When the count reaches DEBOUNCE-1 with botoes still equal to the candidate, the next state SHALL be REGISTRA.
- Any mismatch SHALL return the FSM to ESPERA_BOTAO.
REQ-018 On the transition into REGISTRA, jogada SHALL load the candidate.
REQ-019 jogada_feita SHALL be a Moore output that is 1 only in REGISTRA.
REQ-020 The press-to-output latency SHALL be:
- jogada_feita is high in the cycle following the (DEBOUNCE+1)-th rising edge, counted from the first edge that samples the stable one-hot value in ESPERA_BOTAO.
- For DEBOUNCE=4, that is 5 edges.
REQ-021 REGISTRA SHALL last exactly one cycle and then go to ESPERA_SOLTAR.
REQ-022 In ESPERA_SOLTAR:
- The FSM SHALL require DEBOUNCE consecutive cycles of botoes=0000 before returning to ESPERA_BOTAO, clearing the timeout counter on that return.
- Any nonzero sample SHALL restart the release count.
- A button held indefinitely SHALL never produce a second jogada_feita.
REQ-023 The timeout counter:
- SHALL increment every cycle in ESPERA_BOTAO and FILTRA.
- SHALL hold its value in REGISTRA and ESPERA_SOLTAR.
- SHALL not be cleared by a rejected or bouncing press.
REQ-024 When the timeout counter reaches TIMEOUT-1 in ESPERA_BOTAO or FILTRA, the next state SHALL be ESGOTADO.
REQ-025 When a press completes debouncing in the same cycle that the timeout counter reaches TIMEOUT-1, timeout SHALL win and REGISTRA SHALL not be entered.
REQ-026 timeout SHALL be 1 only in ESGOTADO.
REQ-027 ESGOTADO SHALL ignore botoes and be left only through zera or habilita=0.
REQ-028 jogada SHALL hold its value across OCIOSO and habilita toggling, and SHALL change only on entering REGISTRA, on zera, or on reset.
REQ-029 Counter widths SHALL be sized from the parameters, and counters SHALL never wrap while a state is waiting.

Reset
REQ-030 reset=1 SHALL immediately (asynchronously) force: state OCIOSO, jogada=0000, jogada_feita=0, timeout=0, db_estado=000, both counters=0.
REQ-031 Reset asserted mid-press or during ESGOTADO SHALL discard all progress, and no jogada_feita SHALL follow its release unless habilita=1 and a new full debounce occurs.

Verification
REQ-032 The bench SHALL cover the following directed scenarios, using DEBOUNCE=4, TIMEOUT=20 and a 20 ns clock:
- Clean press: habilita=1, botoes=0010 for 10 cycles -> exactly one jogada_feita pulse, 5 edges after the first sample; jogada=0010; no timeout.
- Bounce: botoes toggles 0001/0000 every 2 cycles for 8 cycles, then holds 0001 -> a single jogada_feita after the stable run; jogada=0001.
- Multiple buttons: botoes=0101 held for 15 cycles -> no jogada_feita; timeout rises once 20 cycles have elapsed in ESPERA_BOTAO; db_estado=5.
- Timeout then recovery: in ESGOTADO, a press of 1000 is ignored; zera for 1 cycle -> timeout=0, jogada=0000; a re-enabled press of 1000 is captured.
- Held button and release: 0100 held for 50 cycles -> one pulse and no timeout; then 0000 for 4 cycles -> db_estado=1.
- Asynchronous reset mid-FILTRA -> all outputs 0 at once, before the next clock edge.
